regfile_dump: RTL and testbench

//  Debug/verification reader for the register file: on request, walks every

---
 rtl/regfile_dump.sv | 153 +++++++++++++++
 tb/tb_regfile_dump.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump
//  Description : Register-file dump engine. On start, walks every register
//                two at a time through the regfile's two read ports, streams
//                each value with its index over valid/ready, and keeps a
//                wrapping 32-bit checksum of all accepted values.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump #(
  parameter  int DATA_WIDTH = 32,
  parameter  int REG_NUM    = 32,
  localparam int AW         = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [AW-1:0]         rf_rs1,
  output logic [AW-1:0]         rf_rs2,
  input  logic [DATA_WIDTH-1:0] rf_out1,
  input  logic [DATA_WIDTH-1:0] rf_out2,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [AW-1:0]         dout_idx,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum
);

  // Pointer carries one extra bit so ptr+2 past the last register is representable.
  localparam int PW = AW + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_SEND0 = 3'd2;
  localparam logic [2:0] ST_SEND1 = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [PW-1:0] C_LAST  = PW'(REG_NUM - 1);
  localparam logic [PW-1:0] C_COUNT = PW'(REG_NUM);

  logic [2:0]            state;
  logic [PW-1:0]         ptr;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;

  logic [PW-1:0]         ptr_inc1;
  logic [PW-1:0]         ptr_inc2;
  logic [31:0]           buf0_32;
  logic [31:0]           buf1_32;

  assign ptr_inc1 = ptr + PW'(1);
  assign ptr_inc2 = ptr + PW'(2);

  // Checksum operands: register values zero-extended or truncated to 32 bits.
  generate
    if (DATA_WIDTH >= 32) begin : g_sum_trunc
      assign buf0_32 = buf0[31:0];
      assign buf1_32 = buf1[31:0];
    end else begin : g_sum_zext
      assign buf0_32 = {{(32 - DATA_WIDTH){1'b0}}, buf0};
      assign buf1_32 = {{(32 - DATA_WIDTH){1'b0}}, buf1};
    end
  endgenerate

  // Read addresses are only presented during READ; a lone tail register reads itself twice.
  always_comb begin
    rf_rs1 = '0;
    rf_rs2 = '0;
    if (state == ST_READ) begin
      rf_rs1 = ptr[AW-1:0];
      rf_rs2 = (ptr_inc1 == C_COUNT) ? ptr[AW-1:0] : ptr_inc1[AW-1:0];
    end
  end

  // Stream outputs are decoded from the state so they hold steady while stalled.
  always_comb begin
    dout       = '0;
    dout_idx   = '0;
    dout_valid = 1'b0;
    case (state)
      ST_SEND0: begin
        dout       = buf0;
        dout_idx   = ptr[AW-1:0];
        dout_valid = 1'b1;
      end
      ST_SEND1: begin
        dout       = buf1;
        dout_idx   = ptr_inc1[AW-1:0];
        dout_valid = 1'b1;
      end
      default: begin
        dout       = '0;
        dout_idx   = '0;
        dout_valid = 1'b0;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);

  // Walk sequencer: abort pre-empts everything (including a same-cycle accept).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      buf0     <= '0;
      buf1     <= '0;
      checksum <= '0;
    end else if (abort && (state != ST_IDLE)) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            ptr      <= '0;
            checksum <= '0;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          buf0  <= rf_out1;
          buf1  <= rf_out2;
          state <= ST_SEND0;
        end
        ST_SEND0: begin
          if (dout_ready) begin
            checksum <= checksum + buf0_32;
            state    <= (ptr == C_LAST) ? ST_FIN : ST_SEND1;
          end
        end
        ST_SEND1: begin
          if (dout_ready) begin
            checksum <= checksum + buf1_32;
            ptr      <= ptr_inc2;
            state    <= (ptr_inc2 >= C_COUNT) ? ST_FIN : ST_READ;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_dump
//  Description : Self-checking bench for regfile_dump (32-register and
//                5-register instances) with regfile models and a beat
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: 32 x 32-bit ----------------
  logic        a_start = 0, a_abort = 0, a_ready = 0;
  logic [4:0]  a_rs1, a_rs2, a_idx;
  logic [31:0] a_out1, a_out2, a_dout, a_checksum;
  logic        a_valid, a_busy, a_done;
  logic [31:0] regs_a [0:31];
  logic        zeroreg_a = 1'b0;

  assign a_out1 = (zeroreg_a && a_rs1 == 5'd0) ? 32'h0 : regs_a[a_rs1];
  assign a_out2 = (zeroreg_a && a_rs2 == 5'd0) ? 32'h0 : regs_a[a_rs2];

  regfile_dump #(.DATA_WIDTH(32), .REG_NUM(32)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .rf_rs1(a_rs1), .rf_rs2(a_rs2), .rf_out1(a_out1), .rf_out2(a_out2),
    .dout(a_dout), .dout_idx(a_idx), .dout_valid(a_valid), .dout_ready(a_ready),
    .busy(a_busy), .done(a_done), .checksum(a_checksum)
  );

  // ---------------- instance B: 5 x 32-bit ----------------
  logic        b_start = 0, b_abort = 0, b_ready = 0;
  logic [2:0]  b_rs1, b_rs2, b_idx;
  logic [31:0] b_out1, b_out2, b_dout, b_checksum;
  logic        b_valid, b_busy, b_done;
  logic [31:0] regs_b [0:7];

  assign b_out1 = regs_b[b_rs1];
  assign b_out2 = regs_b[b_rs2];

  regfile_dump #(.DATA_WIDTH(32), .REG_NUM(5)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .rf_rs1(b_rs1), .rf_rs2(b_rs2), .rf_out1(b_out1), .rf_out2(b_out2),
    .dout(b_dout), .dout_idx(b_idx), .dout_valid(b_valid), .dout_ready(b_ready),
    .busy(b_busy), .done(b_done), .checksum(b_checksum)
  );

  // ---------------- scoreboard ----------------
  int          exp_idx_a[$];
  logic [31:0] exp_val_a[$];
  int          exp_idx_b[$];
  logic [31:0] exp_val_b[$];
  int          beats_a = 0, dones_a = 0, beats_b = 0, dones_b = 0;
  bit          stab_a = 0;
  logic        prev_v = 0, prev_r = 0;
  logic [31:0] prev_d = 0;
  logic [4:0]  prev_i = 0;

  // Pop and compare every beat the DUT is about to hand over at the next edge.
  always @(negedge clk) begin
    int          ei;
    logic [31:0] ev;
    if (a_valid && a_ready && !a_abort && !rst) begin
      beats_a++;
      checks++;
      if (exp_val_a.size() == 0) begin
        failures++;
        $display("FAIL a_beat_unexpected idx=%0d dout=%h required=none", a_idx, a_dout);
      end else begin
        ei = exp_idx_a.pop_front();
        ev = exp_val_a.pop_front();
        if (a_idx !== 5'(ei) || a_dout !== ev) begin
          failures++;
          $display("FAIL a_beat idx=%0d dout=%h required idx=%0d dout=%h", a_idx, a_dout, ei, ev);
        end
      end
    end
    if (b_valid && b_ready && !b_abort && !rst) begin
      beats_b++;
      checks++;
      if (exp_val_b.size() == 0) begin
        failures++;
        $display("FAIL b_beat_unexpected idx=%0d dout=%h required=none", b_idx, b_dout);
      end else begin
        ei = exp_idx_b.pop_front();
        ev = exp_val_b.pop_front();
        if (b_idx !== 3'(ei) || b_dout !== ev) begin
          failures++;
          $display("FAIL b_beat idx=%0d dout=%h required idx=%0d dout=%h", b_idx, b_dout, ei, ev);
        end
      end
    end
    if (a_done) dones_a++;
    if (b_done) dones_b++;
    if (stab_a && prev_v && !prev_r) begin
      checks++;
      if (a_valid !== 1'b1 || a_dout !== prev_d || a_idx !== prev_i) begin
        failures++;
        $display("FAIL a_stall_stable valid=%b idx=%0d dout=%h required valid=1 idx=%0d dout=%h",
                 a_valid, a_idx, a_dout, prev_i, prev_d);
      end
    end
    prev_v = a_valid; prev_r = a_ready; prev_d = a_dout; prev_i = a_idx;
  end

  // ---------------- tasks ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (a_busy !== 1'b0)      begin failures++; $display("FAIL rst_busy actual=%b required=0", a_busy); end
    if (a_valid !== 1'b0)     begin failures++; $display("FAIL rst_valid actual=%b required=0", a_valid); end
    if (a_done !== 1'b0)      begin failures++; $display("FAIL rst_done actual=%b required=0", a_done); end
    if (a_checksum !== 32'h0) begin failures++; $display("FAIL rst_checksum actual=%h required=0", a_checksum); end
    if (a_dout !== 32'h0)     begin failures++; $display("FAIL rst_dout actual=%h required=0", a_dout); end
    if (a_idx !== 5'd0)       begin failures++; $display("FAIL rst_idx actual=%0d required=0", a_idx); end
    if (a_rs1 !== 5'd0 || a_rs2 !== 5'd0) begin failures++; $display("FAIL rst_rs actual=%0d/%0d required=0/0", a_rs1, a_rs2); end
    if (b_busy !== 1'b0)      begin failures++; $display("FAIL rst_b_busy actual=%b required=0", b_busy); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_full_dump(input bit toggle_ready);
    logic [31:0] exp_sum = 0;
    logic [31:0] v;
    for (int i = 0; i < 32; i++) regs_a[i] = 32'(i * 16 + 1);
    zeroreg_a = 1'b0;
    for (int i = 0; i < 32; i++) begin
      v = regs_a[i];
      exp_idx_a.push_back(i); exp_val_a.push_back(v); exp_sum += v;
    end
    beats_a = 0; dones_a = 0;
    stab_a = toggle_ready;
    a_ready = 1'b1;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b1 || a_valid !== 1'b0 || a_rs1 !== 5'd0 || a_rs2 !== 5'd1) begin
      failures++;
      $display("FAIL read_cycle busy=%b valid=%b rs1=%0d rs2=%0d required 1 0 0 1", a_busy, a_valid, a_rs1, a_rs2);
    end
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b1 || a_idx !== 5'd0) begin
      failures++;
      $display("FAIL first_latency valid=%b idx=%0d required valid=1 idx=0", a_valid, a_idx);
    end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1 if (toggle_ready) a_ready = (c % 3 == 2);
      if (!a_busy) break;
    end
    @(negedge clk);
    stab_a = 0;
    a_ready = 1'b1;
    checks += 4;
    if (a_busy !== 1'b0)          begin failures++; $display("FAIL dump_timeout busy=%b required=0", a_busy); end
    if (dones_a != 1)             begin failures++; $display("FAIL dump_done_count actual=%0d required=1", dones_a); end
    if (beats_a != 32 || exp_val_a.size() != 0) begin
      failures++; $display("FAIL dump_beats actual=%0d left=%0d required=32 left=0", beats_a, exp_val_a.size());
    end
    if (a_checksum !== exp_sum)   begin failures++; $display("FAIL dump_checksum actual=%h required=%h", a_checksum, exp_sum); end
    exp_idx_a.delete(); exp_val_a.delete();
  endtask

  task automatic test_odd_tail;
    logic [31:0] exp_sum = 0;
    int last_c = -1, done_c = -1;
    for (int i = 0; i < 8; i++) regs_b[i] = 32'h10 + 32'(i);
    for (int i = 0; i < 5; i++) begin
      exp_idx_b.push_back(i); exp_val_b.push_back(regs_b[i]); exp_sum += regs_b[i];
    end
    beats_b = 0; dones_b = 0; b_ready = 1'b1;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (b_valid && b_ready && b_idx == 3'd4) last_c = c;
      if (b_done) done_c = c;
      if (!b_busy) break;
    end
    checks += 4;
    if (b_busy !== 1'b0 || beats_b != 5 || exp_val_b.size() != 0) begin
      failures++; $display("FAIL tail_beats busy=%b beats=%0d required busy=0 beats=5", b_busy, beats_b);
    end
    if (last_c < 0 || done_c != last_c + 1) begin
      failures++; $display("FAIL tail_done_timing done_cycle=%0d required=%0d", done_c, last_c + 1);
    end
    if (dones_b != 1) begin failures++; $display("FAIL tail_done_count actual=%0d required=1", dones_b); end
    if (b_checksum !== exp_sum) begin failures++; $display("FAIL tail_checksum actual=%h required=%h", b_checksum, exp_sum); end
    exp_idx_b.delete(); exp_val_b.delete();
  endtask

  task automatic test_abort;
    logic [31:0] part;
    bit reached = 0;
    for (int i = 0; i < 32; i++) regs_a[i] = 32'h1000 + 32'(i * 3);
    for (int i = 0; i < 32; i++) begin exp_idx_a.push_back(i); exp_val_a.push_back(regs_a[i]); end
    part = regs_a[0] + regs_a[1] + regs_a[2];
    beats_a = 0; dones_a = 0; a_ready = 1'b1;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (beats_a == 3) begin reached = 1; break; end
    end
    #1 a_abort = 1'b1;
    @(posedge clk); #1 a_abort = 1'b0;
    @(negedge clk);
    checks += 4;
    if (!reached) begin failures++; $display("FAIL abort_reach beats=%0d required=3", beats_a); end
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      failures++; $display("FAIL abort_idle valid=%b busy=%b required 0 0", a_valid, a_busy);
    end
    if (dones_a != 0 || beats_a != 3) begin
      failures++; $display("FAIL abort_no_done dones=%0d beats=%0d required 0 3", dones_a, beats_a);
    end
    if (a_checksum !== part) begin failures++; $display("FAIL abort_checksum actual=%h required=%h", a_checksum, part); end
    exp_idx_a.delete(); exp_val_a.delete();
    test_full_dump(1'b0);
  endtask

  task automatic test_rst_midstream;
    bit reached = 0;
    for (int i = 0; i < 32; i++) regs_a[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 32; i++) begin exp_idx_a.push_back(i); exp_val_a.push_back(regs_a[i]); end
    beats_a = 0; a_ready = 1'b1;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (beats_a == 7) begin reached = 1; break; end
    end
    #1 a_ready = 1'b0; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(negedge clk);
    checks += 2;
    if (!reached) begin failures++; $display("FAIL rst_reach beats=%0d required=7", beats_a); end
    if (a_valid !== 1'b1 || a_idx !== 5'd7 || a_dout !== regs_a[7] || a_busy !== 1'b1) begin
      failures++; $display("FAIL start_while_busy valid=%b idx=%0d dout=%h required 1 7 %h", a_valid, a_idx, a_dout, regs_a[7]);
    end
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_dout !== 32'h0 || a_idx !== 5'd0) begin
      failures++; $display("FAIL async_rst_outputs valid=%b busy=%b done=%b dout=%h idx=%0d required all 0",
                           a_valid, a_busy, a_done, a_dout, a_idx);
    end
    if (a_checksum !== 32'h0) begin failures++; $display("FAIL async_rst_checksum actual=%h required=0", a_checksum); end
    @(posedge clk); #1 rst = 1'b0; a_ready = 1'b1;
    exp_idx_a.delete(); exp_val_a.delete();
  endtask

  task automatic test_zeroreg;
    logic [31:0] exp_sum = 0;
    logic [31:0] v;
    for (int i = 0; i < 32; i++) regs_a[i] = 32'h0100 + 32'(i * 7);
    zeroreg_a = 1'b1;
    regs_a[0] = 32'hdeadbeef;
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'h0 : regs_a[i];
      exp_idx_a.push_back(i); exp_val_a.push_back(v); exp_sum += v;
    end
    beats_a = 0; dones_a = 0; a_ready = 1'b1;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_valid !== 1'b1 || a_idx !== 5'd0 || a_dout !== 32'h0) begin
      failures++; $display("FAIL zeroreg_r0 valid=%b idx=%0d dout=%h required 1 0 0", a_valid, a_idx, a_dout);
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!a_busy) break;
    end
    checks += 2;
    if (a_busy !== 1'b0 || beats_a != 32 || dones_a != 1) begin
      failures++; $display("FAIL zeroreg_run busy=%b beats=%0d dones=%0d required 0 32 1", a_busy, beats_a, dones_a);
    end
    if (a_checksum !== exp_sum) begin failures++; $display("FAIL zeroreg_checksum actual=%h required=%h", a_checksum, exp_sum); end
    zeroreg_a = 1'b0;
    exp_idx_a.delete(); exp_val_a.delete();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs_a[i] = 32'h0;
    for (int i = 0; i < 8; i++) regs_b[i] = 32'h0;
    test_reset;
    test_full_dump(1'b0);
    test_full_dump(1'b1);
    test_odd_tail;
    test_abort;
    test_rst_midstream;
    test_zeroreg;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
